byte_capture_fifo: RTL and testbench

//   Downstream consumer of the 8-bit registered byte stream (q of the 8-bit async-reset

---
 rtl/byte_capture_fifo.sv | 96 +++++++++
 tb/tb_byte_capture_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_capture_fifo.sv
// Show-ahead capture FIFO for a registered byte stream, with occupancy count and a sticky
// overflow flag for bytes dropped while full.
module byte_capture_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne  = AW'(1);
   localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
   localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;

   logic full, empty, push, pop;

   always_comb begin
      full  = (count_q == CntFull);
      empty = (count_q == '0);
      // in_ready deliberately ignores out_ready: a pop on the same edge does not free a slot.
      push  = in_valid & ~full;
      pop   = out_ready & ~empty;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      // A drop on this edge wins over a clear request.
      if (in_valid && full) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      in_ready  = ~full;
      out_valid = ~empty;
      out_data  = empty ? '0 : mem_q[rd_ptr_q];
      count     = count_q;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_byte_capture_fifo.sv
// Directed bench for byte_capture_fifo: stimulus queues expected bytes, a negedge monitor
// pops and compares every byte the DUT hands over.
module tb_byte_capture_fifo;

   logic       clk;
   logic       areset_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       overflow;
   logic       clr_ovf;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   byte_capture_fifo #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: a handshake is visible here, half a cycle before the popping edge.
   always @(negedge clk) begin
      if (areset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got 0x%0h expected no output at %0t", out_data, $time);
         end else begin
            check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset_n  = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;

      // 1. Asynchronous reset, no clock edge involved.
      #2 areset_n = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
      tick();

      // 2. Single byte through.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      exp_q.push_back(8'hA5);
      tick();
      in_valid = 1'b0;
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_data", {24'd0, out_data}, 32'h0A5);
      check("single_count", {29'd0, count}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_empty_valid", {31'd0, out_valid}, 32'd0);
      check("single_empty_data", {24'd0, out_data}, 32'd0);
      check("single_empty_count", {29'd0, count}, 32'd0);

      // 3. Fill, partial drain, refill across the pointer wrap.
      for (int v = 1; v <= 4; v++) begin
         in_valid = 1'b1;
         in_data  = 8'(v);
         exp_q.push_back(8'(v));
         tick();
      end
      in_valid = 1'b0;
      check("fill_count", {29'd0, count}, 32'd4);
      check("fill_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      check("part_drain_count", {29'd0, count}, 32'd2);
      for (int v = 5; v <= 6; v++) begin
         in_valid = 1'b1;
         in_data  = 8'(v);
         exp_q.push_back(8'(v));
         tick();
      end
      in_valid = 1'b0;
      check("refill_count", {29'd0, count}, 32'd4);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      check("wrap_drain_count", {29'd0, count}, 32'd0);

      // 4. Drop while full, with a simultaneous pop and clear; set must win.
      for (int v = 1; v <= 4; v++) begin
         in_valid = 1'b1;
         in_data  = 8'(v);
         exp_q.push_back(8'(v));
         tick();
      end
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      clr_ovf   = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      clr_ovf   = 1'b0;
      out_ready = 1'b0;
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_count", {29'd0, count}, 32'd3);
      check("ovf_head", {24'd0, out_data}, 32'h002);
      tick();
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_clear", {31'd0, overflow}, 32'd0);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      check("ovf_drain_count", {29'd0, count}, 32'd0);

      // 5. Streaming with one entry in flight.
      in_valid = 1'b1;
      in_data  = 8'h10;
      exp_q.push_back(8'h10);
      tick();
      for (int v = 8'h11; v <= 8'h1F; v++) begin
         in_valid  = 1'b1;
         in_data   = 8'(v);
         out_ready = 1'b1;
         exp_q.push_back(8'(v));
         tick();
         check("stream_count", {29'd0, count}, 32'd1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("stream_end_count", {29'd0, count}, 32'd0);

      // 6. Reset pulse between edges discards everything.
      for (int v = 8'hA1; v <= 8'hA3; v++) begin
         in_valid = 1'b1;
         in_data  = 8'(v);
         exp_q.push_back(8'(v));
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_count", {29'd0, count}, 32'd3);
      #2 areset_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_data", {24'd0, out_data}, 32'd0);
      check("mid_rst_count", {29'd0, count}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      areset_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      exp_q.push_back(8'h77);
      tick();
      in_valid = 1'b0;
      check("post_rst_head", {24'd0, out_data}, 32'h077);
      check("post_rst_count", {29'd0, count}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      check("sb_leftover", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
